// File: rtl/id_ex_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg_pkg
// Brief    : Shared widths, ALU op classes and EX control bundle type.
// Revision : 1.0
// ============================================================================
package id_ex_stage_reg_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_CNT_W  = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_IMM   = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_OP_ADD};

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg_if
// Brief    : ID-side inputs and EX-side outputs of the ID/EX stage register.
// Revision : 1.0
// ============================================================================
interface id_ex_stage_reg_if
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = DEF_CNT_W
) ();

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_uses_rt;
    logic [DATA_W-1:0] id_read_data1;
    logic [DATA_W-1:0] id_read_data2;
    logic [DATA_W-1:0] id_imm;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_mem_to_reg;
    logic              id_alu_src;
    logic              id_reg_dst;
    logic [1:0]        id_alu_op;
    logic              flush;

    logic              ex_valid;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_read_data1;
    logic [DATA_W-1:0] ex_read_data2;
    logic [DATA_W-1:0] ex_imm;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;
    logic              ex_alu_src;
    logic              ex_reg_dst;
    logic [1:0]        ex_alu_op;
    logic [REG_AW-1:0] ex_write_reg_addr;
    logic              pc_write_en;
    logic              if_id_write_en;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_read_data1, id_read_data2,
               id_imm, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_alu_src, id_reg_dst, id_alu_op, flush,
        input  ex_valid, ex_rs, ex_rt, ex_rd, ex_read_data1, ex_read_data2, ex_imm,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
               ex_reg_dst, ex_alu_op, ex_write_reg_addr, pc_write_en, if_id_write_en,
               stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_read_data1, id_read_data2,
               id_imm, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_alu_src, id_reg_dst, id_alu_op, flush,
        output ex_valid, ex_rs, ex_rt, ex_rd, ex_read_data1, ex_read_data2, ex_imm,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
               ex_reg_dst, ex_alu_op, ex_write_reg_addr, pc_write_en, if_id_write_en,
               stall_count, flush_count
    );

endinterface
`default_nettype wire

// File: rtl/id_ex_stage_reg_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : load_use_detect
// Brief    : Combinational load-use hazard term between EX load and ID consumer.
// Revision : 1.0
// ============================================================================
module load_use_detect
    import id_ex_stage_reg_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  wire logic              i_id_valid,
    input  wire logic [REG_AW-1:0] i_id_rs,
    input  wire logic [REG_AW-1:0] i_id_rt,
    input  wire logic              i_id_uses_rt,
    input  wire logic              i_ex_valid,
    input  wire logic              i_ex_mem_read,
    input  wire logic [REG_AW-1:0] i_ex_rt,
    output      logic              o_hazard
);

    logic w_load_live;
    logic w_rs_match;
    logic w_rt_match;

    // A load targeting $0 produces nothing to wait for
    assign w_load_live = i_ex_valid & i_ex_mem_read & (i_ex_rt != REG_AW'(REG_ZERO));
    assign w_rs_match  = (i_ex_rt == i_id_rs);
    assign w_rt_match  = i_id_uses_rt & (i_ex_rt == i_id_rt);
    assign o_hazard    = i_id_valid & w_load_live & (w_rs_match | w_rt_match);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg
// Brief    : ID/EX pipeline register with load-use stall and flush bubbling.
// Revision : 1.0
// ============================================================================
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = DEF_CNT_W
) (
    input wire logic    clk,
    input wire logic    rst,
    id_ex_stage_reg_if.slave bus
);

    logic              w_hazard;
    logic              w_stall;
    logic              w_bubble;
    ex_ctrl_t          w_id_ctrl;

    logic              r_valid;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;
    logic [DATA_W-1:0] r_imm;
    ex_ctrl_t          r_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .i_id_valid    (bus.id_valid),
        .i_id_rs       (bus.id_rs),
        .i_id_rt       (bus.id_rt),
        .i_id_uses_rt  (bus.id_uses_rt),
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rt       (r_rt),
        .o_hazard      (w_hazard)
    );

    // Flush outranks the stall: the dependent instruction is being squashed anyway
    assign w_stall  = w_hazard & ~bus.flush;
    assign w_bubble = bus.flush | w_stall;

    always_comb begin
        w_id_ctrl = CTRL_BUBBLE;
        if (bus.id_valid) begin
            w_id_ctrl = '{bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
                          bus.id_mem_to_reg, bus.id_alu_src, bus.id_reg_dst, bus.id_alu_op};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_bubble) begin
            r_valid <= 1'b0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_data1 <= '0;
            r_data2 <= '0;
            r_imm   <= '0;
            r_ctrl  <= CTRL_BUBBLE;
        end else begin
            r_valid <= bus.id_valid;
            r_rs    <= bus.id_rs;
            r_rt    <= bus.id_rt;
            r_rd    <= bus.id_rd;
            r_data1 <= bus.id_read_data1;
            r_data2 <= bus.id_read_data2;
            r_imm   <= bus.id_imm;
            r_ctrl  <= w_id_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (bus.flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ex_valid          = r_valid;
    assign bus.ex_rs             = r_rs;
    assign bus.ex_rt             = r_rt;
    assign bus.ex_rd             = r_rd;
    assign bus.ex_read_data1     = r_data1;
    assign bus.ex_read_data2     = r_data2;
    assign bus.ex_imm            = r_imm;
    assign bus.ex_reg_write      = r_ctrl.reg_write;
    assign bus.ex_mem_read       = r_ctrl.mem_read;
    assign bus.ex_mem_write      = r_ctrl.mem_write;
    assign bus.ex_mem_to_reg     = r_ctrl.mem_to_reg;
    assign bus.ex_alu_src        = r_ctrl.alu_src;
    assign bus.ex_reg_dst        = r_ctrl.reg_dst;
    assign bus.ex_alu_op         = r_ctrl.alu_op;
    assign bus.ex_write_reg_addr = r_ctrl.reg_dst ? r_rd : r_rt;
    assign bus.pc_write_en       = ~w_stall;
    assign bus.if_id_write_en    = ~w_stall;
    assign bus.stall_count       = r_stall_cnt;
    assign bus.flush_count       = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage_reg
// Brief    : Directed + random bench for id_ex_stage_reg against a spec-level model.
// Revision : 1.0
// ============================================================================
module tb_id_ex_stage_reg;

    localparam int CNT_MAX = 15;
    // control byte: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[1:0]}
    localparam logic [7:0] C_LW    = 8'hD8;
    localparam logic [7:0] C_RTYPE = 8'h86;
    localparam logic [7:0] C_ADDI  = 8'h88;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) bus ();

    id_ex_stage_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected contents of the EX side
    logic        m_valid;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_d1, m_d2, m_imm;
    logic [7:0]  m_ctrl;
    int          m_scnt, m_fcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_rs = '0; m_rt = '0; m_rd = '0;
        m_d1 = '0; m_d2 = '0; m_imm = '0; m_ctrl = '0;
        m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic ut, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm,
                          input logic [7:0] c, input logic fl);
        bus.id_valid = v;  bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_uses_rt = ut;
        bus.id_read_data1 = d1; bus.id_read_data2 = d2; bus.id_imm = imm;
        {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg,
         bus.id_alu_src, bus.id_reg_dst, bus.id_alu_op} = c;
        bus.flush = fl;
    endtask

    function automatic logic exp_hazard();
        // EX holds a live load into a nonzero register that ID needs
        return bus.id_valid && m_valid && m_ctrl[6] && (m_rt != 5'd0) &&
               ((m_rt == bus.id_rs) || (bus.id_uses_rt && (m_rt == bus.id_rt)));
    endfunction

    task automatic check_ex(input string tag);
        chk({tag, "_valid"}, bus.ex_valid, m_valid);
        chk({tag, "_rs"}, bus.ex_rs, m_rs);
        chk({tag, "_rt"}, bus.ex_rt, m_rt);
        chk({tag, "_rd"}, bus.ex_rd, m_rd);
        chk({tag, "_d1"}, bus.ex_read_data1, m_d1);
        chk({tag, "_d2"}, bus.ex_read_data2, m_d2);
        chk({tag, "_imm"}, bus.ex_imm, m_imm);
        chk({tag, "_ctrl"}, {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
            bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_reg_dst, bus.ex_alu_op}, m_ctrl);
        chk({tag, "_wra"}, bus.ex_write_reg_addr, m_ctrl[2] ? m_rd : m_rt);
        chk({tag, "_scnt"}, bus.stall_count, m_scnt);
        chk({tag, "_fcnt"}, bus.flush_count, m_fcnt);
    endtask

    // One clock: check enables before the edge, advance the model, check EX after it
    task automatic cycle(input string tag);
        logic stl;
        #1;
        stl = exp_hazard() && !bus.flush;
        chk({tag, "_pcwe"}, bus.pc_write_en, !stl);
        chk({tag, "_ifidwe"}, bus.if_id_write_en, !stl);
        @(posedge clk);
        if (bus.flush || stl) begin
            m_valid = 1'b0; m_rs = '0; m_rt = '0; m_rd = '0;
            m_d1 = '0; m_d2 = '0; m_imm = '0; m_ctrl = '0;
        end else begin
            m_valid = bus.id_valid; m_rs = bus.id_rs; m_rt = bus.id_rt; m_rd = bus.id_rd;
            m_d1 = bus.id_read_data1; m_d2 = bus.id_read_data2; m_imm = bus.id_imm;
            m_ctrl = bus.id_valid ? {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
                     bus.id_mem_to_reg, bus.id_alu_src, bus.id_reg_dst, bus.id_alu_op} : 8'h00;
        end
        if (stl && m_scnt < CNT_MAX) m_scnt++;
        if (bus.flush && m_fcnt < CNT_MAX) m_fcnt++;
        #1;
        check_ex(tag);
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
        model_reset();
        #2;
        check_ex("rst");
        chk("rst_pcwe", bus.pc_write_en, 1'b1);
        chk("rst_ifidwe", bus.if_id_write_en, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // lw $2 then dependent add $3,$2,$4: one stall, then add enters EX
        set_in(1, 5'd1, 5'd2, 5'd0, 0, 32'h100, 32'h0, 32'h8, C_LW, 0);
        cycle("lw2");
        set_in(1, 5'd2, 5'd4, 5'd3, 1, 32'hAA, 32'hBB, 32'h0, C_RTYPE, 0);
        cycle("add_stall");
        chk("tp1_bubble_valid", bus.ex_valid, 1'b0);
        chk("tp1_scnt", bus.stall_count, 4'd1);
        cycle("add_go");
        chk("tp1_add_rd", bus.ex_write_reg_addr, 5'd3);

        // lw $2 then addi $3,$5,4: rt not a source, no stall
        do_reset();
        set_in(1, 5'd1, 5'd2, 5'd0, 0, 32'h100, 32'h0, 32'h8, C_LW, 0);
        cycle("lw2b");
        set_in(1, 5'd5, 5'd3, 5'd0, 0, 32'h55, 32'h66, 32'h4, C_ADDI, 0);
        cycle("addi");
        chk("tp2_rs", bus.ex_rs, 5'd5);
        chk("tp2_imm", bus.ex_imm, 32'h4);

        // lw $0 never stalls
        do_reset();
        set_in(1, 5'd1, 5'd0, 5'd0, 0, 32'h0, 32'h0, 32'h0, C_LW, 0);
        cycle("lw0");
        set_in(1, 5'd0, 5'd0, 5'd3, 1, 32'h0, 32'h0, 32'h0, C_RTYPE, 0);
        cycle("use0");
        chk("tp3_scnt", bus.stall_count, 4'd0);

        // hazard and flush together: flush wins
        do_reset();
        set_in(1, 5'd1, 5'd2, 5'd0, 0, 32'h0, 32'h0, 32'h8, C_LW, 0);
        cycle("lw2c");
        set_in(1, 5'd2, 5'd4, 5'd3, 1, 32'h1, 32'h2, 32'h0, C_RTYPE, 1);
        cycle("hz_flush");
        chk("tp4_fcnt", bus.flush_count, 4'd1);
        chk("tp4_scnt", bus.stall_count, 4'd0);

        // plain R-type and an invalid slot with live control inputs
        set_in(1, 5'd1, 5'd2, 5'd3, 1, 32'h11, 32'h22, 32'h0, C_RTYPE, 0);
        cycle("rtype");
        chk("tp5_wra", bus.ex_write_reg_addr, 5'd3);
        chk("tp5_d1", bus.ex_read_data1, 32'h11);
        set_in(0, 5'd7, 5'd8, 5'd9, 1, 32'h33, 32'h44, 32'h5, C_LW, 0);
        cycle("invalid");

        // asynchronous reset in the middle of a stall cycle
        set_in(1, 5'd1, 5'd2, 5'd0, 0, 32'h0, 32'h0, 32'h8, C_LW, 0);
        cycle("lw2d");
        set_in(1, 5'd2, 5'd4, 5'd3, 1, 32'h1, 32'h2, 32'h0, C_RTYPE, 0);
        #3;
        chk("arst_pre_pcwe", bus.pc_write_en, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check_ex("arst");
        chk("arst_pcwe", bus.pc_write_en, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("post_arst");

        // random traffic over a small register set to provoke hazards and saturation
        for (int i = 0; i < 400; i++) begin
            logic [7:0] c;
            c = 8'($urandom);
            if ($urandom_range(0, 2) == 0) c[6] = 1'b1;
            set_in($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), $urandom, $urandom, $urandom, c,
                   $urandom_range(0, 9) == 0);
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
